mult_rnd_sat: RTL and testbench



---
 rtl/mult_rnd_sat_pkg.sv | 33 +++
 rtl/mult_rnd_sat_if.sv | 45 ++++
 rtl/mult_rnd_sat_lane.sv | 60 ++++++
 rtl/mult_rnd_sat.sv | 83 ++++++++
 tb/tb_mult_rnd_sat.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_rnd_sat_pkg.sv
// Shared widths and the output clip helper for the multi-lane multiply/round/saturate pipeline.
package mult_rnd_sat_pkg;

  localparam int DEF_A_BITS  = 16;
  localparam int DEF_B_BITS  = 8;
  localparam int DEF_P_BITS  = 26;
  localparam int DEF_O_BITS  = 16;
  localparam int DEF_LANES   = 4;
  localparam int DEF_SH_BITS = 5;

  localparam int SUM_BITS = DEF_P_BITS + 1;
  localparam int MAX_O    = (2 ** (DEF_O_BITS - 1)) - 1;
  localparam int MIN_O    = -(2 ** (DEF_O_BITS - 1));

  // Wide enough for any sum width this block is built with; callers sign-extend into it.
  localparam int CLIP_W = 64;

  function automatic logic signed [CLIP_W-1:0] clip_signed(
    input logic signed [CLIP_W-1:0] value,
    input int                       o_bits
  );
    logic signed [CLIP_W-1:0] hi;
    hi = (CLIP_W'(1) <<< (o_bits - 1)) - CLIP_W'(1);
    if (value > hi) begin
      return hi;
    end else if (value < ~hi) begin
      return ~hi;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/mult_rnd_sat_if.sv
// Bus bundle for mult_rnd_sat; sticky saturation ports exist only with MULT_RND_SAT_STICKY_EN.
interface mult_rnd_sat_if import mult_rnd_sat_pkg::*; #(
  parameter int A_BITS  = DEF_A_BITS,
  parameter int B_BITS  = DEF_B_BITS,
  parameter int P_BITS  = DEF_P_BITS,
  parameter int O_BITS  = DEF_O_BITS,
  parameter int LANES   = DEF_LANES,
  parameter int SH_BITS = DEF_SH_BITS
);

  // Flow control: a beat is accepted on a rising clk edge with en=1 and in_valid=1;
  // it appears with out_valid=1 after exactly three en=1 edges. en=0 freezes everything.
  logic                      en;
  logic                      in_valid;
  logic [LANES*A_BITS-1:0]   a;
  logic [LANES*B_BITS-1:0]   b;
  logic [P_BITS-1:0]         offset;
  logic [SH_BITS-1:0]        shift;
  logic                      out_valid;
  logic [LANES*O_BITS-1:0]   p;
  logic [LANES-1:0]          sat;
`ifdef MULT_RND_SAT_STICKY_EN
  logic                      sat_clr;
  logic [LANES-1:0]          sat_sticky;
`endif

  modport master (
    output en, in_valid, a, b, offset, shift,
`ifdef MULT_RND_SAT_STICKY_EN
    output sat_clr,
    input  sat_sticky,
`endif
    input  out_valid, p, sat
  );

  modport slave (
    input  en, in_valid, a, b, offset, shift,
`ifdef MULT_RND_SAT_STICKY_EN
    input  sat_clr,
    output sat_sticky,
`endif
    output out_valid, p, sat
  );

endinterface

// File: rtl/mult_rnd_sat_lane.sv
// One lane of the datapath: multiply, offset + rounding shift, clip. Valid control lives in the top.
module mult_rnd_sat_lane import mult_rnd_sat_pkg::*; #(
  parameter int A_BITS  = DEF_A_BITS,
  parameter int B_BITS  = DEF_B_BITS,
  parameter int P_BITS  = DEF_P_BITS,
  parameter int O_BITS  = DEF_O_BITS,
  parameter int SH_BITS = DEF_SH_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic signed [A_BITS-1:0]  a_i,
  input  logic signed [B_BITS-1:0]  b_i,
  input  logic signed [P_BITS-1:0]  off_i,
  input  logic [SH_BITS-1:0]        sh_i,
  input  logic                      v2_i,
  output logic signed [O_BITS-1:0]  p_o,
  output logic                      sat_o
);

  localparam int SW = P_BITS + 1;

  logic signed [A_BITS+B_BITS-1:0] prod_full;
  logic signed [P_BITS-1:0]        prod_d, prod_q;
  logic signed [SW-1:0]            rnd, sum, res_d, res_q;
  logic signed [CLIP_W-1:0]        res_ext, clip_v;
  logic signed [O_BITS-1:0]        p_d, p_q;
  logic                            sat_d, sat_q;

  always_comb begin
    prod_full = a_i * b_i;
    prod_d    = P_BITS'(prod_full);
    // Half-LSB rounding bias ahead of the floor shift; none when no shift.
    rnd       = (sh_i != '0) ? (SW'(1) << (sh_i - SH_BITS'(1))) : '0;
    sum       = SW'(prod_q) + SW'(off_i) + rnd;
    res_d     = sum >>> sh_i;
    res_ext   = CLIP_W'(res_q);
    clip_v    = clip_signed(res_ext, O_BITS);
    p_d       = clip_v[O_BITS-1:0];
    sat_d     = v2_i & (clip_v != res_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      res_q  <= '0;
      p_q    <= '0;
      sat_q  <= 1'b0;
    end else if (en_i) begin
      prod_q <= prod_d;
      res_q  <= res_d;
      p_q    <= p_d;
      sat_q  <= sat_d;
    end
  end

  assign p_o   = p_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/mult_rnd_sat.sv
// Multi-lane pipelined signed multiply with offset, rounding shift and saturation, 3-cycle latency.
// Optional sticky saturation flags are built when MULT_RND_SAT_STICKY_EN is defined.
module mult_rnd_sat import mult_rnd_sat_pkg::*; #(
  parameter int A_BITS  = DEF_A_BITS,
  parameter int B_BITS  = DEF_B_BITS,
  parameter int P_BITS  = DEF_P_BITS,
  parameter int O_BITS  = DEF_O_BITS,
  parameter int LANES   = DEF_LANES,
  parameter int SH_BITS = DEF_SH_BITS
) (
  input  logic          clk,
  input  logic          rst,
  mult_rnd_sat_if.slave bus
);

  localparam logic [SH_BITS-1:0] SH_MAX = SH_BITS'(P_BITS - 1);

  logic                     v1_q, v2_q, ov_q;
  logic [P_BITS-1:0]        off_q;
  logic [SH_BITS-1:0]       sh_d, sh_q;
  logic [LANES*O_BITS-1:0]  p_w;
  logic [LANES-1:0]         sat_w;

  // Oversized shifts collapse to the widest meaningful shift of the product/sum.
  always_comb sh_d = (bus.shift > SH_MAX) ? SH_MAX : bus.shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      off_q <= '0;
      sh_q  <= '0;
    end else if (bus.en) begin
      v1_q  <= bus.in_valid;
      v2_q  <= v1_q;
      ov_q  <= v2_q;
      off_q <= bus.offset;
      sh_q  <= sh_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mult_rnd_sat_lane #(
      .A_BITS (A_BITS),
      .B_BITS (B_BITS),
      .P_BITS (P_BITS),
      .O_BITS (O_BITS),
      .SH_BITS(SH_BITS)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en_i (bus.en),
      .a_i  (bus.a[i*A_BITS +: A_BITS]),
      .b_i  (bus.b[i*B_BITS +: B_BITS]),
      .off_i(off_q),
      .sh_i (sh_q),
      .v2_i (v2_q),
      .p_o  (p_w[i*O_BITS +: O_BITS]),
      .sat_o(sat_w[i])
    );
  end

  assign bus.out_valid = ov_q;
  assign bus.p         = p_w;
  assign bus.sat       = sat_w;

`ifdef MULT_RND_SAT_STICKY_EN
  logic [LANES-1:0] sticky_q;

  // Runs off the registered outputs independent of en; a new saturation beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~{LANES{bus.sat_clr}}) | (sat_w & {LANES{ov_q}});
    end
  end

  assign bus.sat_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_mult_rnd_sat.sv
// Directed bench for mult_rnd_sat: hand-computed beats, stall/hold, reset flush, optional sticky flags.
module tb_mult_rnd_sat;
  import mult_rnd_sat_pkg::*;

  localparam int A  = 16;
  localparam int B  = 8;
  localparam int P  = 26;
  localparam int O  = 16;
  localparam int L  = 4;
  localparam int SH = 5;
  localparam int W  = L*O + L;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_rnd_sat_if #(.A_BITS(A), .B_BITS(B), .P_BITS(P), .O_BITS(O), .LANES(L), .SH_BITS(SH)) bus ();

  mult_rnd_sat #(.A_BITS(A), .B_BITS(B), .P_BITS(P), .O_BITS(O), .LANES(L), .SH_BITS(SH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   exp_q[$];
  int             out_cyc_q[$];
  int             cyc = 0;
  int             nbeat = 0;
  int             base;
  bit             mon_on = 1'b0;
  logic           adv, rs;
  logic [W-1:0]   e_beat;
  logic [W:0]     snap;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int p0, input int p1, input int p2, input int p3,
                                        input logic [L-1:0] s);
    return {s, 16'(p3), 16'(p2), 16'(p1), 16'(p0)};
  endfunction

  function automatic logic [L*A-1:0] va(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [L*B-1:0] vb(input int b0, input int b1, input int b2, input int b3);
    return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [L*A-1:0] av, input logic [L*B-1:0] bv,
                      input int off, input int sh, input logic [W-1:0] e);
    bus.a        = av;
    bus.b        = bv;
    bus.offset   = P'(off);
    bus.shift    = SH'(sh);
    bus.in_valid = 1'b1;
    bus.en       = 1'b1;
    exp_q.push_back(e);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Output monitor: pops one expected beat per advancing edge with out_valid, checks holds on stalls.
  always begin
    @(posedge clk);
    adv = bus.en;
    rs  = rst;
    cyc++;
    #1;
    if (mon_on && !rs) begin
      if (adv) begin
        if (bus.out_valid) begin
          check("spurious_beat", 128'(exp_q.size() == 0), 128'd0);
          if (exp_q.size() != 0) begin
            e_beat = exp_q.pop_front();
            check($sformatf("beat%0d", nbeat), 128'({bus.sat, bus.p}), 128'(e_beat));
            nbeat++;
            out_cyc_q.push_back(cyc);
          end
        end else begin
          check("sat_idle", 128'(bus.sat), 128'd0);
        end
      end else begin
        check("stall_hold", 128'({bus.out_valid, bus.sat, bus.p}), 128'(snap));
      end
    end
    snap = {bus.out_valid, bus.sat, bus.p};
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.offset = '0; bus.shift = '0;
`ifdef MULT_RND_SAT_STICKY_EN
    bus.sat_clr = 1'b0;
`endif
    rst = 1'b1;
    step();
    bus.en = 1'b1;
    step();
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_p",         128'(bus.p),         128'd0);
    check("rst_sat",       128'(bus.sat),       128'd0);
`ifdef MULT_RND_SAT_STICKY_EN
    check("rst_sticky",    128'(bus.sat_sticky), 128'd0);
`endif
    rst = 1'b0;
    mon_on = 1'b1;

    // Mixed saturation at shift 0; then latency probe before it emerges.
    send(va(1000, -300, 5, 32767), vb(100, 7, 3, -128), 0, 0,
         pack(32767, -2100, 15, -32768, 4'b1001));
    step();
    check("lat_e2", 128'(bus.out_valid), 128'd0);
    step();
    // Rounding shift 2, floor on negatives.
    send(va(1000, -300, 5, -1), vb(100, 7, 3, 1), 0, 2, pack(25000, -525, 4, 0, 4'b0000));
    send(va(-32768, 0, 5, -7), vb(-128, 0, 3, 3), 1, 1, pack(32767, 1, 8, -10, 4'b0001));
    // Shift 31 clamps to 25.
    send(va(32767, 0, -32768, 32767), vb(127, 0, -128, -128), 33554431, 31, pack(1, 1, 1, 1, 4'b0000));
    // Exact edges of the output range versus one past them.
    send(va(32767, -32768, -32768, 16384), vb(1, 1, -1, 2), 0, 0,
         pack(32767, -32768, 32767, 32767, 4'b1100));
    send(va(100, -100, 0, 1), vb(1, 1, 0, 1), -40000, 0, pack(-32768, -32768, -32768, -32768, 4'b1111));
    send(va(3, -3, 20, -20), vb(1, 1, 1, 1), -5, 3, pack(0, -1, 2, -3, 4'b0000));
    repeat (4) step();

    // Five-beat stream with a two-cycle stall after the third beat.
    base = cyc;
    out_cyc_q.delete();
    for (int k = 1; k <= 3; k++)
      send(va(100*k, 100*k, 100*k, 100*k), vb(1, 2, 3, 4), 0, 0,
           pack(100*k, 200*k, 300*k, 400*k, 4'b0000));
    bus.en = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = va(32767, 32767, 32767, 32767);
    bus.b = vb(127, 127, 127, 127);
    step();
    step();
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 4; k <= 5; k++)
      send(va(100*k, 100*k, 100*k, 100*k), vb(1, 2, 3, 4), 0, 0,
           pack(100*k, 200*k, 300*k, 400*k, 4'b0000));
    repeat (4) step();
    check("stream_count", 128'(out_cyc_q.size()), 128'd5);
    if (out_cyc_q.size() == 5) begin
      check("stream_first", 128'(out_cyc_q[0] - base), 128'd3);
      check("stream_last",  128'(out_cyc_q[4] - base), 128'd9);
    end

    // Reset with two beats in flight: both are dropped.
    send(va(1000, 1000, 1000, 1000), vb(100, 100, 100, 100), 0, 0, pack(0, 0, 0, 0, 4'b0000));
    send(va(7, 7, 7, 7), vb(7, 7, 7, 7), 0, 0, pack(0, 0, 0, 0, 4'b0000));
    rst = 1'b1;
    step();
    check("flush_out_valid", 128'(bus.out_valid), 128'd0);
    check("flush_p",         128'(bus.p),         128'd0);
    check("flush_sat",       128'(bus.sat),       128'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (6) step();

`ifdef MULT_RND_SAT_STICKY_EN
    send(va(1000, 0, 0, 0), vb(100, 0, 0, 0), 0, 0, pack(32767, 0, 0, 0, 4'b0001));
    repeat (3) step();
    check("sticky_set", 128'(bus.sat_sticky), 128'd1);
    for (int k = 0; k < 10; k++)
      send(va(1, 1, 1, 1), vb(1, 1, 1, 1), 0, 0, pack(1, 1, 1, 1, 4'b0000));
    repeat (4) step();
    check("sticky_hold", 128'(bus.sat_sticky), 128'd1);
    bus.sat_clr = 1'b1;
    step();
    bus.sat_clr = 1'b0;
    check("sticky_clr", 128'(bus.sat_sticky), 128'd0);
    send(va(1000, 0, 0, 0), vb(100, 0, 0, 0), 0, 0, pack(32767, 0, 0, 0, 4'b0001));
    step();
    step();
    bus.sat_clr = 1'b1;
    step();
    bus.sat_clr = 1'b0;
    check("sticky_set_wins", 128'(bus.sat_sticky), 128'd1);
    repeat (3) step();
`endif

    check("drain", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
